thermostat_ctrl: RTL and testbench

//  Sequencer and decision block between the I2C temperature-sensor master and the HVAC outputs.
//  - Periodically requests a sensor read over a req/done handshake.
//  - Times out reads that never complete, and flags the sensor faulty after repeated timeouts.
//  - Drives mutually exclusive heat/cool outputs using setpoint, hysteresis and minimum-dwell rules.

---
 rtl/thermostat_pkg.sv | 24 ++
 rtl/tstat_tick_gen.sv | 30 +++
 rtl/thermostat_ctrl.sv | 141 ++++++++++++++
 tb/tb_thermostat_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/thermostat_pkg.sv
// Shared encodings and state types for the thermostat controller.
// Imported by the top and its sub-module.
package thermostat_pkg;

    localparam int TEMP_W_DEF = 8;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_HEAT = 2'b01;
    localparam logic [1:0] MODE_COOL = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_WAIT = 2'd1,
        SEQ_EVAL = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        OUT_OFF  = 2'd0,
        OUT_HEAT = 2'd1,
        OUT_COOL = 2'd2
    } out_state_t;

endpackage

// File: rtl/tstat_tick_gen.sv
// Modulo-N counter: counts 0..N-1 while enabled, held at 0 otherwise,
// and raises a one-cycle tick on the wrap.
module tstat_tick_gen #(
    parameter int N = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(N - 1));
    assign tick = en && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/thermostat_ctrl.sv
// Thermostat sequencer: periodic sensor reads with timeout/fault tracking,
// and a heat/cool output FSM with hysteresis and minimum dwell.
module thermostat_ctrl
    import thermostat_pkg::*;
#(
    parameter int TEMP_W        = TEMP_W_DEF,
    parameter int SAMPLE_PERIOD = 200000,
    parameter int RD_TIMEOUT    = 4000,
    parameter int FAULT_LIMIT   = 3,
    parameter int MIN_DWELL     = 6000
) (
    input  logic              clk_200kHz,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [3:0]        hyst,
    output logic              rd_req,
    input  logic              rd_done,
    input  logic [TEMP_W-1:0] rd_data,
    output logic [TEMP_W-1:0] temp_cur,
    output logic              temp_valid,
    output logic              heat_on,
    output logic              cool_on,
    output logic              sensor_fault
);

    localparam int WT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam int FC_W = $clog2(FAULT_LIMIT + 1);
    localparam int DW_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;

    seq_state_t        seq_state, seq_next;
    out_state_t        out_state, out_next;
    logic              tick;
    logic [WT_W-1:0]   wait_cnt;
    logic [FC_W-1:0]   fault_cnt;
    logic [DW_W-1:0]   dwell_cnt;
    logic              wait_hit, accept, timeout_ev, eval;
    logic [TEMP_W:0]   lo_w, hi_w;
    logic [TEMP_W-1:0] lo, hi;
    logic              force_off, heat_ok, cool_ok;

    tstat_tick_gen #(.N(SAMPLE_PERIOD)) u_period (
        .clk   (clk_200kHz),
        .rst_n (reset_n),
        .en    (enable),
        .tick  (tick)
    );

    // rd_done beats a coincident timeout; both are ignored outside WAIT.
    assign wait_hit   = (wait_cnt == WT_W'(RD_TIMEOUT - 1));
    assign accept     = enable && (seq_state == SEQ_WAIT) && rd_done;
    assign timeout_ev = enable && (seq_state == SEQ_WAIT) && !rd_done && wait_hit;
    assign rd_req     = (seq_state == SEQ_WAIT);
    assign eval       = (seq_state == SEQ_EVAL);

    always_ff @(posedge clk_200kHz or negedge reset_n) begin
        if (!reset_n) seq_state <= SEQ_IDLE;
        else          seq_state <= seq_next;
    end

    always_comb begin
        seq_next = seq_state;
        case (seq_state)
            SEQ_IDLE: if (tick) seq_next = SEQ_WAIT;
            SEQ_WAIT: begin
                if (rd_done)       seq_next = SEQ_EVAL;
                else if (wait_hit) seq_next = SEQ_IDLE;
            end
            SEQ_EVAL: seq_next = SEQ_IDLE;
            default:  seq_next = SEQ_IDLE;
        endcase
        if (!enable) seq_next = SEQ_IDLE;
    end

    always_ff @(posedge clk_200kHz or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt     <= '0;
            fault_cnt    <= '0;
            sensor_fault <= 1'b0;
            temp_cur     <= '0;
            temp_valid   <= 1'b0;
        end else begin
            wait_cnt   <= (seq_state == SEQ_WAIT && seq_next == SEQ_WAIT) ? wait_cnt + 1'b1 : '0;
            temp_valid <= accept;
            if (accept) begin
                temp_cur     <= rd_data;
                fault_cnt    <= '0;
                sensor_fault <= 1'b0;
            end else if (timeout_ev) begin
                if (fault_cnt != FC_W'(FAULT_LIMIT)) fault_cnt <= fault_cnt + 1'b1;
                if (fault_cnt >= FC_W'(FAULT_LIMIT - 1)) sensor_fault <= 1'b1;
            end
        end
    end

    // Thresholds are widened by one bit so under/overflow clamps instead of wrapping.
    assign lo_w = {1'b0, setpoint} - (TEMP_W + 1)'(hyst);
    assign hi_w = {1'b0, setpoint} + (TEMP_W + 1)'(hyst);
    assign lo   = lo_w[TEMP_W] ? '0 : lo_w[TEMP_W-1:0];
    assign hi   = hi_w[TEMP_W] ? '1 : hi_w[TEMP_W-1:0];

    assign force_off = !enable || (mode == MODE_OFF) || sensor_fault;
    assign heat_ok   = (mode == MODE_HEAT) || (mode == MODE_AUTO);
    assign cool_ok   = (mode == MODE_COOL) || (mode == MODE_AUTO);

    always_ff @(posedge clk_200kHz or negedge reset_n) begin
        if (!reset_n) out_state <= OUT_OFF;
        else          out_state <= out_next;
    end

    always_comb begin
        out_next = out_state;
        if (force_off) begin
            out_next = OUT_OFF;
        end else if (eval && dwell_cnt == '0) begin
            case (out_state)
                OUT_OFF: begin
                    if (heat_ok && temp_cur < lo)      out_next = OUT_HEAT;
                    else if (cool_ok && temp_cur > hi) out_next = OUT_COOL;
                end
                OUT_HEAT: if (temp_cur >= setpoint || !heat_ok) out_next = OUT_OFF;
                OUT_COOL: if (temp_cur <= setpoint || !cool_ok) out_next = OUT_OFF;
                default:  out_next = OUT_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_200kHz or negedge reset_n) begin
        if (!reset_n)                  dwell_cnt <= '0;
        else if (out_next != out_state) dwell_cnt <= DW_W'(MIN_DWELL - 1);
        else if (dwell_cnt != '0)      dwell_cnt <= dwell_cnt - 1'b1;
    end

    assign heat_on = (out_state == OUT_HEAT);
    assign cool_on = (out_state == OUT_COOL);

    a_heat_cool_excl: assert property (@(posedge clk_200kHz) disable iff (!reset_n)
        !(heat_on && cool_on));

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl: reads, hysteresis, dwell, timeouts, races,
// threshold saturation and asynchronous reset.
module tb_thermostat_ctrl;
    import thermostat_pkg::*;

    logic       clk_200kHz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       enable     = 1'b0;
    logic [1:0] mode       = MODE_OFF;
    logic [7:0] setpoint   = '0;
    logic [3:0] hyst       = '0;
    logic       rd_done    = 1'b0;
    logic [7:0] rd_data    = '0;
    logic       rd_req, temp_valid, heat_on, cool_on, sensor_fault;
    logic [7:0] temp_cur;

    int n_pass = 0, n_fail = 0, n_total = 0, n_both = 0;

    thermostat_ctrl #(
        .TEMP_W(8), .SAMPLE_PERIOD(100), .RD_TIMEOUT(50), .FAULT_LIMIT(3), .MIN_DWELL(500)
    ) dut (
        .clk_200kHz(clk_200kHz), .reset_n(reset_n), .enable(enable), .mode(mode),
        .setpoint(setpoint), .hyst(hyst), .rd_req(rd_req), .rd_done(rd_done),
        .rd_data(rd_data), .temp_cur(temp_cur), .temp_valid(temp_valid),
        .heat_on(heat_on), .cool_on(cool_on), .sensor_fault(sensor_fault)
    );

    always #5 clk_200kHz = ~clk_200kHz;

    always @(negedge clk_200kHz) if (reset_n && heat_on && cool_on) n_both++;

    task automatic step();
        @(posedge clk_200kHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 300 && rd_req !== 1'b1; i++) step();
        check({tag, "_req_rise"}, rd_req, 1);
    endtask

    // Answers a read d cycles after rd_req is seen; returns two cycles after rd_done.
    task automatic do_read(input logic [7:0] val, input int d, input string tag);
        wait_req(tag);
        repeat (d) step();
        rd_data = val;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check({tag, "_temp"}, temp_cur, val);
        check({tag, "_valid"}, temp_valid, 1);
        check({tag, "_req_drop"}, rd_req, 0);
        step();
        check({tag, "_valid_once"}, temp_valid, 0);
    endtask

    task automatic do_timeout(input string tag);
        int n;
        wait_req(tag);
        n = 0;
        while (rd_req === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check({tag, "_wait_len"}, n, 50);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_heat"}, heat_on, 0);
        check({tag, "_cool"}, cool_on, 0);
        check({tag, "_req"}, rd_req, 0);
        check({tag, "_temp"}, temp_cur, 0);
        check({tag, "_valid"}, temp_valid, 0);
        check({tag, "_fault"}, sensor_fault, 0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        do_reset("rst");

        // T1 basic read, mode OFF
        enable = 1'b1; setpoint = 8'd22; hyst = 4'd2;
        repeat (50) step();
        check("t1_no_early_req", rd_req, 0);
        do_read(8'd25, 20, "t1");
        check("t1_heat", heat_on, 0);
        check("t1_cool", cool_on, 0);

        // T2 heat hysteresis: lo = 20; on at 19, holds 500 cycles, off at 22 after dwell
        mode = MODE_HEAT;
        do_read(8'd19, 20, "t2_on");
        check("t2_heat_on", heat_on, 1);
        for (int k = 1; k <= 5; k++) begin
            do_read((k == 1) ? 8'd21 : 8'd22, 20, "t2");
            check("t2_heat_hold", heat_on, (k < 5) ? 1 : 0);
            check("t2_cool", cool_on, 0);
        end

        // T3 dwell in AUTO: lo = 21, hi = 23
        do_reset("t3_rst");
        mode = MODE_AUTO; setpoint = 8'd22; hyst = 4'd1;
        do_read(8'd18, 20, "t3_on");
        check("t3_heat_on", heat_on, 1);
        for (int k = 1; k <= 10; k++) begin
            do_read(8'd30, 20, "t3");
            check("t3_heat", heat_on, (k < 5) ? 1 : 0);
            check("t3_cool", cool_on, (k == 10) ? 1 : 0);
        end

        // T4 timeouts: fault after the third, cooler forced off the next cycle
        do_timeout("t4_to1");
        check("t4_fault1", sensor_fault, 0);
        do_timeout("t4_to2");
        check("t4_fault2", sensor_fault, 0);
        do_timeout("t4_to3");
        check("t4_fault3", sensor_fault, 1);
        check("t4_cool_still", cool_on, 1);
        step();
        check("t4_cool_forced", cool_on, 0);
        check("t4_heat_forced", heat_on, 0);
        do_read(8'd22, 20, "t4_good");
        check("t4_fault_clr", sensor_fault, 0);

        // T5 race: rd_done on the timeout cycle is accepted and clears the count
        do_timeout("t5_to1");
        do_timeout("t5_to2");
        check("t5_fault_pre", sensor_fault, 0);
        do_read(8'd40, 49, "t5_race");
        check("t5_fault_race", sensor_fault, 0);
        do_timeout("t5_to3");
        do_timeout("t5_to4");
        check("t5_fault_post", sensor_fault, 0);

        // T5 enable drop mid-WAIT; late rd_done ignored
        wait_req("t5_dis");
        repeat (10) step();
        enable = 1'b0;
        step();
        check("t5_dis_req", rd_req, 0);
        rd_data = 8'd77;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("t5_late_valid", temp_valid, 0);
        check("t5_late_temp", temp_cur, 40);
        step();
        check("t5_late_valid2", temp_valid, 0);
        enable = 1'b1;

        // T6 saturation
        do_reset("t6_rst");
        mode = MODE_HEAT; setpoint = 8'd1; hyst = 4'd15;
        do_read(8'd0, 20, "t6_lo");
        check("t6_no_heat", heat_on, 0);
        mode = MODE_COOL; setpoint = 8'd250;
        do_read(8'd255, 20, "t6_hi");
        check("t6_no_cool", cool_on, 0);
        setpoint = 8'd20; hyst = 4'd2;
        do_read(8'd23, 20, "t6_cool");
        check("t6_cool_on", cool_on, 1);

        // Async reset mid-read, then a stray rd_done
        wait_req("t6_mid");
        repeat (5) step();
        do_reset("t6_async");
        rd_data = 8'd99;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check("t6_stray_valid", temp_valid, 0);
        check("t6_stray_temp", temp_cur, 0);

        check("both_on_never", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
